// File: rtl/dict_attack_ctrl_if.sv
// rtl/dict_attack_ctrl_if.sv - BRAM read port and encrypter start/done handshake bundle
interface dict_attack_ctrl_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 8
);
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] aes_data;
  logic [DATA_W-1:0] aes_key;
  logic              aes_decrypt;
  logic              aes_start;
  logic              aes_done;
  logic [DATA_W-1:0] aes_out;

  modport master (
    output mem_en, mem_addr, aes_data, aes_key, aes_decrypt, aes_start,
    input  mem_dout, aes_done, aes_out
  );

  modport slave (
    input  mem_en, mem_addr, aes_data, aes_key, aes_decrypt, aes_start,
    output mem_dout, aes_done, aes_out
  );
endinterface

// File: rtl/dict_attack_ctrl.sv
// rtl/dict_attack_ctrl.sv - fetch cipher/key/hash, try a decrypt, then walk the dictionary
module dict_attack_ctrl #(
  parameter int                DATA_W      = 128,
  parameter int                ADDR_W      = 8,
  parameter int                CIPHER_ADDR = 0,
  parameter int                KEY_ADDR    = 1,
  parameter int                HASH_ADDR   = 2,
  parameter int                DICT_START  = 3,
  parameter int                DICT_SIZE   = 4,
  parameter int                RD_LAT      = 1,
  parameter int                AES_TIMEOUT = 64,
  parameter logic [DATA_W-1:0] KNOWN_PLAIN = "Discombobulateme"
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                clear,
  dict_attack_ctrl_if.master  bus,
  output logic [2:0]          state,
  output logic [2:0]          led,
  output logic [ADDR_W-1:0]   match_idx,
  output logic                match_dec,
  output logic                timeout_err
);
  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam int TMO_W = $clog2(AES_TIMEOUT + 1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(AES_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DICT_SIZE - 1);
  localparam logic [ADDR_W-1:0] A_CIPH   = ADDR_W'(CIPHER_ADDR);
  localparam logic [ADDR_W-1:0] A_KEY    = ADDR_W'(KEY_ADDR);
  localparam logic [ADDR_W-1:0] A_HASH   = ADDR_W'(HASH_ADDR);
  localparam logic [ADDR_W-1:0] A_DICT   = ADDR_W'(DICT_START);

  typedef enum logic [3:0] {
    IDLE, FETCH_C, FETCH_K, FETCH_H, DEC_GO, DEC_WAIT,
    DICT_RD, DICT_GO, DICT_WAIT, SUCCESS, FAIL
  } fsm_e;

  fsm_e              fsm_q, fsm_d;
  logic              start_q, start_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] cipher_q, cipher_d, key_q, key_d, hash_q, hash_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] aes_data_q, aes_data_d, aes_key_q, aes_key_d;
  logic              aes_decrypt_q, aes_decrypt_d, aes_start_q, aes_start_d;
  logic [2:0]        led_q, led_d;
  logic [ADDR_W-1:0] match_idx_q, match_idx_d;
  logic              match_dec_q, match_dec_d, timeout_err_q, timeout_err_d;
  logic              lat_done, tmo_hit;

  function automatic logic [2:0] state_code(input fsm_e s);
    case (s)
      FETCH_C, FETCH_K, FETCH_H, DEC_GO, DEC_WAIT: return 3'd1;
      DICT_RD, DICT_GO, DICT_WAIT:                 return 3'd2;
      SUCCESS:                                     return 3'd3;
      FAIL:                                        return 3'd4;
      default:                                     return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] led_code(input logic [2:0] s);
    case (s)
      3'd1, 3'd2: return 3'b100;
      3'd3:       return 3'b010;
      3'd4:       return 3'b001;
      default:    return 3'b011;
    endcase
  endfunction

  assign lat_done = (lat_q == LAT_LAST);
  assign tmo_hit  = (tmo_q == TMO_LAST);

  always_comb begin
    fsm_d         = fsm_q;
    start_d       = start;
    lat_d         = lat_q;
    tmo_d         = tmo_q;
    idx_d         = idx_q;
    cipher_d      = cipher_q;
    key_d         = key_q;
    hash_d        = hash_q;
    mem_en_d      = mem_en_q;
    mem_addr_d    = mem_addr_q;
    aes_data_d    = aes_data_q;
    aes_key_d     = aes_key_q;
    aes_decrypt_d = aes_decrypt_q;
    aes_start_d   = 1'b0;
    match_idx_d   = match_idx_q;
    match_dec_d   = match_dec_q;
    timeout_err_d = timeout_err_q;

    case (fsm_q)
      IDLE: begin
        if (start && !start_q) begin
          fsm_d      = FETCH_C;
          mem_en_d   = 1'b1;
          mem_addr_d = A_CIPH;
          lat_d      = '0;
        end
      end
      FETCH_C: begin
        if (lat_done) begin
          cipher_d   = bus.mem_dout;
          mem_addr_d = A_KEY;
          lat_d      = '0;
          fsm_d      = FETCH_K;
        end else lat_d = lat_q + 1'b1;
      end
      FETCH_K: begin
        if (lat_done) begin
          key_d      = bus.mem_dout;
          mem_addr_d = A_HASH;
          lat_d      = '0;
          fsm_d      = FETCH_H;
        end else lat_d = lat_q + 1'b1;
      end
      FETCH_H: begin
        if (lat_done) begin
          hash_d   = bus.mem_dout;
          mem_en_d = 1'b0;
          fsm_d    = DEC_GO;
        end else lat_d = lat_q + 1'b1;
      end
      DEC_GO: begin
        aes_data_d    = cipher_q;
        aes_key_d     = key_q;
        aes_decrypt_d = 1'b1;
        aes_start_d   = 1'b1;
        tmo_d         = '0;
        fsm_d         = DEC_WAIT;
      end
      // done wins over a timeout expiring in the same cycle
      DEC_WAIT: begin
        if (bus.aes_done) begin
          if (bus.aes_out == KNOWN_PLAIN) begin
            match_dec_d = 1'b1;
            fsm_d       = SUCCESS;
          end else begin
            idx_d         = '0;
            aes_decrypt_d = 1'b0;
            mem_en_d      = 1'b1;
            mem_addr_d    = A_DICT;
            lat_d         = '0;
            fsm_d         = DICT_RD;
          end
        end else if (tmo_hit) begin
          timeout_err_d = 1'b1;
          fsm_d         = FAIL;
        end else tmo_d = tmo_q + 1'b1;
      end
      DICT_RD: begin
        if (lat_done) begin
          aes_data_d = bus.mem_dout;
          mem_en_d   = 1'b0;
          fsm_d      = DICT_GO;
        end else lat_d = lat_q + 1'b1;
      end
      DICT_GO: begin
        aes_start_d = 1'b1;
        tmo_d       = '0;
        fsm_d       = DICT_WAIT;
      end
      DICT_WAIT: begin
        if (bus.aes_done) begin
          if (bus.aes_out == hash_q) begin
            match_idx_d = idx_q;
            fsm_d       = SUCCESS;
          end else if (idx_q == IDX_LAST) begin
            fsm_d = FAIL;
          end else begin
            idx_d      = idx_q + 1'b1;
            mem_en_d   = 1'b1;
            mem_addr_d = A_DICT + idx_q + 1'b1;
            lat_d      = '0;
            fsm_d      = DICT_RD;
          end
        end else if (tmo_hit) begin
          timeout_err_d = 1'b1;
          fsm_d         = FAIL;
        end else tmo_d = tmo_q + 1'b1;
      end
      SUCCESS, FAIL: begin
        if (clear) begin
          match_idx_d   = '0;
          match_dec_d   = 1'b0;
          timeout_err_d = 1'b0;
          aes_decrypt_d = 1'b1;
          fsm_d         = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase

    led_d = led_code(state_code(fsm_d));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q         <= IDLE;
      start_q       <= 1'b0;
      lat_q         <= '0;
      tmo_q         <= '0;
      idx_q         <= '0;
      cipher_q      <= '0;
      key_q         <= '0;
      hash_q        <= '0;
      mem_en_q      <= 1'b0;
      mem_addr_q    <= '0;
      aes_data_q    <= '0;
      aes_key_q     <= '0;
      aes_decrypt_q <= 1'b1;
      aes_start_q   <= 1'b0;
      led_q         <= 3'b000;
      match_idx_q   <= '0;
      match_dec_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      start_q       <= start_d;
      lat_q         <= lat_d;
      tmo_q         <= tmo_d;
      idx_q         <= idx_d;
      cipher_q      <= cipher_d;
      key_q         <= key_d;
      hash_q        <= hash_d;
      mem_en_q      <= mem_en_d;
      mem_addr_q    <= mem_addr_d;
      aes_data_q    <= aes_data_d;
      aes_key_q     <= aes_key_d;
      aes_decrypt_q <= aes_decrypt_d;
      aes_start_q   <= aes_start_d;
      led_q         <= led_d;
      match_idx_q   <= match_idx_d;
      match_dec_q   <= match_dec_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.mem_en      = mem_en_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.aes_data    = aes_data_q;
  assign bus.aes_key     = aes_key_q;
  assign bus.aes_decrypt = aes_decrypt_q;
  assign bus.aes_start   = aes_start_q;
  assign state           = state_code(fsm_q);
  assign led             = led_q;
  assign match_idx       = match_idx_q;
  assign match_dec       = match_dec_q;
  assign timeout_err     = timeout_err_q;
endmodule

// File: tb/tb_dict_attack_ctrl.sv
// tb/tb_dict_attack_ctrl.sv - directed bench with BRAM and encrypter models for dict_attack_ctrl
module tb_dict_attack_ctrl;
  localparam int AES_LAT = 5;
  localparam logic [127:0] KP = "Discombobulateme";
  localparam logic [127:0] K  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic       clk = 1'b0;
  logic       reset, start, clear;
  logic [2:0] state, led;
  logic [7:0] match_idx;
  logic       match_dec, timeout_err;

  dict_attack_ctrl_if #(.DATA_W(128), .ADDR_W(8)) ifc ();

  dict_attack_ctrl #(.AES_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .bus(ifc),
    .state(state), .led(led), .match_idx(match_idx),
    .match_dec(match_dec), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  logic [127:0] mem [0:255];
  int           rd_cnt [0:255];
  int           base_rd [0:255];
  int           n_start = 0, n_enc = 0, n_dec = 0, n_done = 0;
  bit           aes_respond = 1'b1;
  logic         pend = 1'b0;
  int           cd = 0;
  logic [127:0] m_out = '0;
  int           n_chk = 0, n_pass = 0;
  int           b_start, b_enc, b_dec, b_done;

  function automatic logic [127:0] enc(input logic [127:0] d, input logic [127:0] k);
    return d ^ {k[63:0], k[127:64]} ^ 128'h5a;
  endfunction

  always @(posedge clk) begin
    if (ifc.mem_en) begin
      ifc.mem_dout <= mem[ifc.mem_addr];
      rd_cnt[ifc.mem_addr] <= rd_cnt[ifc.mem_addr] + 1;
    end
  end

  always @(posedge clk) begin
    ifc.aes_done <= 1'b0;
    if (ifc.aes_start) begin
      n_start <= n_start + 1;
      if (ifc.aes_decrypt) n_dec <= n_dec + 1;
      else n_enc <= n_enc + 1;
      m_out <= ifc.aes_decrypt ? (ifc.aes_data ^ ifc.aes_key) : enc(ifc.aes_data, ifc.aes_key);
      pend  <= aes_respond;
      cd    <= AES_LAT - 1;
    end else if (pend) begin
      if (cd == 0) begin
        ifc.aes_done <= 1'b1;
        ifc.aes_out  <= m_out;
        n_done       <= n_done + 1;
        pend         <= 1'b0;
      end else cd <= cd - 1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic snap();
    base_rd = rd_cnt;
    b_start = n_start;
    b_enc   = n_enc;
    b_dec   = n_dec;
    b_done  = n_done;
  endtask

  task automatic wait_state(input logic [2:0] exp, input string tag);
    int i = 0;
    while (state !== exp && i < 400) begin
      tick(1);
      i++;
    end
    chk(tag, state, exp);
  endtask

  task automatic wait_aes_start(input string tag);
    int i = 0;
    while (ifc.aes_start !== 1'b1 && i < 200) begin
      tick(1);
      i++;
    end
    chk(tag, ifc.aes_start, 1'b1);
  endtask

  task automatic setup_dict(input logic [127:0] hash);
    mem[0] = 128'h1;
    mem[1] = K;
    mem[2] = hash;
    for (int i = 3; i < 8; i++) mem[i] = 128'h1000 + 128'(i);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = '0;
      rd_cnt[i] = 0;
    end
    reset = 1'b0; start = 1'b0; clear = 1'b0;
    tick(2);
    chk("rst_state", state, 3'd0);
    chk("rst_led", led, 3'b000);
    chk("rst_mem_en", ifc.mem_en, 1'b0);
    chk("rst_decrypt", ifc.aes_decrypt, 1'b1);
    reset = 1'b1;
    tick(1);
    chk("rel_led", led, 3'b011);

    // 1: decrypt hit
    mem[0] = KP ^ K; mem[1] = K; mem[2] = 128'hbeef;
    snap();
    pulse_start();
    wait_state(3'd3, "t1_state");
    chk("t1_led", led, 3'b010);
    chk("t1_match_dec", match_dec, 1'b1);
    chk("t1_dec_starts", n_dec - b_dec, 1);
    chk("t1_enc_starts", n_enc - b_enc, 0);
    for (int a = 0; a < 3; a++) chk($sformatf("t1_rd%0d", a), rd_cnt[a] - base_rd[a], 2);
    chk("t1_dict_rd", (rd_cnt[3] - base_rd[3]) + (rd_cnt[6] - base_rd[6]), 0);
    do_clear();
    chk("t1_clr_dec", match_dec, 1'b0);

    // 2: dictionary hit at index 2
    setup_dict(enc(128'h1005, K));
    snap();
    pulse_start();
    wait_state(3'd3, "t2_state");
    chk("t2_match_idx", match_idx, 8'd2);
    chk("t2_match_dec", match_dec, 1'b0);
    chk("t2_encs", n_enc - b_enc, 3);
    chk("t2_rd5", rd_cnt[5] - base_rd[5], 2);
    chk("t2_rd6", rd_cnt[6] - base_rd[6], 0);
    chk("t2_decrypt", ifc.aes_decrypt, 1'b0);
    do_clear();

    // 3: full dictionary miss
    setup_dict(enc(128'hffff, K));
    snap();
    pulse_start();
    wait_state(3'd4, "t3_state");
    chk("t3_led", led, 3'b001);
    chk("t3_tmo", timeout_err, 1'b0);
    chk("t3_encs", n_enc - b_enc, 4);
    chk("t3_rd3", rd_cnt[3] - base_rd[3], 2);
    chk("t3_rd6", rd_cnt[6] - base_rd[6], 2);
    chk("t3_rd7", rd_cnt[7] - base_rd[7], 0);
    do_clear();

    // 4: start during DICT ignored, clear, rerun
    setup_dict(enc(128'h1005, K));
    snap();
    pulse_start();
    wait_state(3'd2, "t4_dict");
    pulse_start();
    wait_state(3'd3, "t4_state");
    chk("t4_starts", n_start - b_start, 4);
    chk("t4_rd0", rd_cnt[0] - base_rd[0], 2);
    do_clear();
    chk("t4_clr_state", state, 3'd0);
    chk("t4_clr_led", led, 3'b011);
    chk("t4_clr_idx", match_idx, 8'd0);
    chk("t4_clr_decrypt", ifc.aes_decrypt, 1'b1);
    pulse_start();
    chk("t4_re_en", ifc.mem_en, 1'b1);
    chk("t4_re_addr", ifc.mem_addr, 8'd0);
    wait_state(3'd3, "t4_re_state");
    do_clear();

    // 5: reset during DICT_WAIT, then late aes_done
    setup_dict(enc(128'hffff, K));
    pulse_start();
    wait_state(3'd2, "t5_dict");
    wait_aes_start("t5_enc_start");
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("t5_state", state, 3'd0);
    chk("t5_led", led, 3'b000);
    chk("t5_mem", {ifc.mem_en, ifc.mem_addr}, 9'd0);
    chk("t5_aes_ctl", {ifc.aes_start, ifc.aes_decrypt}, 2'b01);
    chk("t5_aes_data", ifc.aes_data, 128'd0);
    chk("t5_aes_key", ifc.aes_key, 128'd0);
    chk("t5_flags", {match_idx, match_dec, timeout_err}, 10'd0);
    reset = 1'b1;
    snap();
    tick(8);
    chk("t5_late_done", n_done - b_done, 1);
    chk("t5_state_after", state, 3'd0);
    chk("t5_no_start", n_start - b_start, 0);
    chk("t5_led_after", led, 3'b011);

    // 6: encrypter never answers
    aes_respond = 1'b0;
    mem[0] = 128'h1; mem[1] = K;
    snap();
    pulse_start();
    wait_aes_start("t6_start");
    tick(15);
    chk("t6_before", state, 3'd1);
    tick(1);
    chk("t6_state", state, 3'd4);
    chk("t6_tmo", timeout_err, 1'b1);
    chk("t6_led", led, 3'b001);
    tick(5);
    chk("t6_starts", n_start - b_start, 1);
    aes_respond = 1'b1;
    do_clear();
    chk("t6_clr_tmo", timeout_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dict_attack_ctrl.md
Name: dict_attack_ctrl

Overview:
- Synthesisable, parametrised successor to the top-level cracking controller.
- Fetches ciphertext, key and target hash from the SD-simulation BRAM, then runs a decrypt attempt against a known plaintext.
- On a miss, walks a DICT_SIZE-entry dictionary, encrypting each word and comparing the result with the hash.
- Drives the encrypter through a start/done handshake and reports state, LEDs and the matching index; no `#` delays anywhere.

Parameters:
- DATA_W, 128: width of memory words, key and cipher data.
- ADDR_W, 8: BRAM address width.
- CIPHER_ADDR, 0: address of the ciphertext word.
- KEY_ADDR, 1: address of the key word.
- HASH_ADDR, 2: address of the hashed password.
- DICT_START, 3: first dictionary address.
- DICT_SIZE, 4: number of dictionary entries; must be ≥1 and DICT_START+DICT_SIZE ≤ 2^ADDR_W.
- RD_LAT, 1: BRAM read latency in cycles (≥1).
- AES_TIMEOUT, 64: maximum cycles from aes_start to aes_done before abort.
- KNOWN_PLAIN, "Discombobulateme": DATA_W-bit plaintext matched in the decrypt phase.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset (low on a clk edge resets the block).
- start  in  1  level; rising edge (registered internally) begins an attack when in WAIT.
- clear  in  1  returns SUCCESS/FAIL to WAIT; ignored elsewhere.
- mem_en  out  1  BRAM enable.
- mem_addr  out  ADDR_W  BRAM address.
- mem_dout  in  DATA_W  BRAM read data, valid RD_LAT cycles after the address.
- aes_data  out  DATA_W  encrypter data input.
- aes_key  out  DATA_W  encrypter key.
- aes_decrypt  out  1  1 = decrypt, 0 = encrypt.
- aes_start  out  1  one-cycle start pulse.
- aes_done  in  1  one-cycle completion pulse; aes_out valid in the same cycle.
- aes_out  in  DATA_W  encrypter result.
- state  out  3  0 WAIT, 1 DECRYPT, 2 DICT, 3 SUCCESS, 4 FAIL.
- led  out  3  RGB LED.
- match_idx  out  ADDR_W  dictionary index (0-based) of the hit.
- match_dec  out  1  success came from the decrypt phase.
- timeout_err  out  1  FAIL was caused by an AES timeout.

Behaviour:
- Reset (reset low at an edge): state=0, led=000, mem_en=0, mem_addr=0, aes_start=0, aes_decrypt=1, aes_data=0, aes_key=0, match_idx=0, match_dec=0, timeout_err=0, internal registers cleared. The first cycle after release shows led=011.
- led is registered from state: WAIT 011, DECRYPT/DICT 100, SUCCESS 010, FAIL 001.
- Internal FSM: IDLE, FETCH_C, FETCH_K, FETCH_H, DEC_GO, DEC_WAIT, DICT_RD, DICT_GO, DICT_WAIT, SUCCESS, FAIL.
  - state=1 covers FETCH_* and DEC_*; state=2 covers DICT_*.
- IDLE: on a start rising edge go to FETCH_C. A start edge in any other state is ignored.
- FETCH_x: drive mem_addr to the respective address with mem_en=1. Wait exactly RD_LAT cycles, then latch mem_dout into the cipher, key or hash register.
  - Order: cipher, key, hash; total 3·(RD_LAT+1) cycles.
- DEC_GO: aes_data=cipher, aes_key=key, aes_decrypt=1; pulse aes_start for 1 cycle, then DEC_WAIT.
  - aes_data, aes_key and aes_decrypt are held stable until aes_done.
- DEC_WAIT: on aes_done, compare aes_out with KNOWN_PLAIN.
  - Equal → SUCCESS, match_dec=1.
  - Else → DICT_RD with index=0, aes_decrypt=0.
- DICT_RD: mem_addr=DICT_START+index; after RD_LAT cycles latch the word into aes_data, then DICT_GO (pulse aes_start), then DICT_WAIT.
- DICT_WAIT: on aes_done, if aes_out==hash → SUCCESS with match_idx=index.
  - Else if index==DICT_SIZE-1 → FAIL.
  - Else index+1 → DICT_RD.
  - Exactly DICT_SIZE encryptions are issued on a full miss; no address beyond DICT_START+DICT_SIZE-1 is read.
- Timeout: a cycle counter starts at aes_start. If AES_TIMEOUT cycles elapse in DEC_WAIT or DICT_WAIT without aes_done → FAIL, timeout_err=1.
- aes_done outside *_WAIT is ignored.
- SUCCESS/FAIL: hold all outputs. clear=1 → IDLE, which clears match_dec, timeout_err and match_idx; aes_decrypt returns to 1. start is ignored here.
- Simultaneous events:
  - reset low has priority over everything.
  - aes_done in the same cycle the timeout expires counts as done, not timeout.
- Reset mid-operation aborts immediately; no aes_start is issued after the reset edge.

Test Plan:
1. Bench AES model: decrypt returns KNOWN_PLAIN for mem[0]/mem[1], 5-cycle latency; pulse start. → reads at addresses 0,1,2; one aes_start with aes_decrypt=1; state=3, led=010, match_dec=1, zero dictionary reads.
2. Decrypt miss; hash = encrypt(mem[5]). → encryptions at addresses 3,4,5 only; state=3, match_idx=2, match_dec=0.
3. Decrypt miss; no dictionary match, DICT_SIZE=4. → exactly 4 encryptions at addresses 3–6, no read of 7; state=4, led=001, timeout_err=0.
4. Pulse start during DICT. → ignored. In SUCCESS assert clear for 1 cycle. → state=0, led=011 next cycle, match_idx=0; a new start reruns from address 0.
5. Drive reset low for one edge during DICT_WAIT, then a late aes_done. → all outputs at reset values, aes_done ignored, state remains 0.
6. AES_TIMEOUT=16, aes_done never asserted. → 16 cycles after aes_start: state=4, timeout_err=1, aes_start stays low.
